// File: rtl/cell_char_pkg.sv
// Shared types and constants for the standard-cell characterisation sequencer.
package cell_char_pkg;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_SETTLE = 2'd1,
    ST_SAMPLE = 2'd2,
    ST_FINISH = 2'd3
  } state_e;

  // ZN of AOI21 for vectors {A,B1,B2}: ~(A | (B1 & B2))
  localparam logic [7:0] AOI21_TRUTH_TBL = 8'h07;

  function automatic int cnt_width(input int max_val);
    return (max_val > 1) ? $clog2(max_val) : 1;
  endfunction

endpackage

// File: rtl/cell_char_vec_gen.sv
// Vector/loop counter: steps through all 2**N_IN vectors, LOOPS times, and flags the final one.
module cell_char_vec_gen
  import cell_char_pkg::*;
#(
  parameter int N_IN  = 3,
  parameter int LOOPS = 1
) (
  input  logic            ck_i,
  input  logic            rst_i,
  input  logic            clear_i,
  input  logic            step_i,
  output logic [N_IN-1:0] vec_o,
  output logic            last_o
);

  localparam int LW = cnt_width(LOOPS);

  logic [N_IN-1:0] vec_q;
  logic [LW-1:0]   loop_q;

  always_ff @(posedge ck_i or posedge rst_i) begin
    if (rst_i) begin
      vec_q  <= '0;
      loop_q <= '0;
    end else if (clear_i) begin
      vec_q  <= '0;
      loop_q <= '0;
    end else if (step_i) begin
      vec_q <= vec_q + N_IN'(1);
      if (&vec_q) loop_q <= loop_q + LW'(1);
    end
  end

  assign vec_o  = vec_q;
  assign last_o = (&vec_q) && (loop_q == LW'(LOOPS - 1));

endmodule

// File: rtl/cell_char_seq.sv
// Characterisation sequencer: drives every input vector into one CUT, samples ZN after a
// settle window, checks it against a golden truth table and reports PASS/FAIL.
//
// state  | meaning
// IDLE   | waiting for START
// SETTLE | CUT_IN held, settle timer counting down
// SAMPLE | ZN compared against the truth table for the current vector
// FINISH | DONE/PASS issued for one cycle
module cell_char_seq
  import cell_char_pkg::*;
#(
  parameter int                N_IN       = 3,
  parameter logic [2**N_IN-1:0] TRUTH_TBL = AOI21_TRUTH_TBL,
  parameter int                SETTLE_CYC = 2,
  parameter int                LOOPS      = 1,
  parameter int                CNT_W      = 8
) (
  input  logic             CK,
  input  logic             RST,
  input  logic             START,
  input  logic             ABORT,
  output logic [N_IN-1:0]  CUT_IN,
  input  logic             CUT_ZN,
  output logic             BUSY,
  output logic             DONE,
  output logic             PASS,
  output logic             FAIL_VALID,
  output logic [N_IN-1:0]  FAIL_VEC,
  output logic [CNT_W-1:0] ERR_CNT
);

  localparam int             CW         = cnt_width(SETTLE_CYC);
  localparam logic [CW-1:0]  SETTLE_RLD = CW'(SETTLE_CYC - 1);

  state_e           state_q;
  logic [CW-1:0]    settle_q;
  logic             busy_q;
  logic             done_q;
  logic             pass_q;
  logic             fail_valid_q;
  logic [N_IN-1:0]  fail_vec_q;
  logic [CNT_W-1:0] err_q;
  logic [CNT_W-1:0] err_d;

  logic [N_IN-1:0]  vec;
  logic             last_vec;
  logic             start_ok;
  logic             abort_run;
  logic             mismatch;
  logic             vec_clear;
  logic             vec_step;

  assign start_ok  = (state_q == ST_IDLE) && START && !ABORT;
  assign abort_run = ABORT && ((state_q == ST_SETTLE) || (state_q == ST_SAMPLE));
  assign mismatch  = (state_q == ST_SAMPLE) && (CUT_ZN != TRUTH_TBL[vec]);
  assign err_d     = (mismatch && !(&err_q)) ? err_q + CNT_W'(1) : err_q;

  // The vector counter doubles as CUT_IN, so clearing it also parks the CUT at 0.
  assign vec_clear = start_ok || abort_run || ((state_q == ST_SAMPLE) && last_vec);
  assign vec_step  = (state_q == ST_SAMPLE) && !ABORT && !last_vec;

  cell_char_vec_gen #(
    .N_IN  (N_IN),
    .LOOPS (LOOPS)
  ) u_vec_gen (
    .ck_i    (CK),
    .rst_i   (RST),
    .clear_i (vec_clear),
    .step_i  (vec_step),
    .vec_o   (vec),
    .last_o  (last_vec)
  );

  always_ff @(posedge CK or posedge RST) begin
    if (RST) begin
      state_q      <= ST_IDLE;
      settle_q     <= '0;
      busy_q       <= 1'b0;
      done_q       <= 1'b0;
      pass_q       <= 1'b0;
      fail_valid_q <= 1'b0;
      fail_vec_q   <= '0;
      err_q        <= '0;
    end else begin
      done_q       <= 1'b0;
      fail_valid_q <= 1'b0;
      case (state_q)
        ST_IDLE: begin
          if (start_ok) begin
            state_q  <= ST_SETTLE;
            settle_q <= SETTLE_RLD;
            busy_q   <= 1'b1;
            err_q    <= '0;
            pass_q   <= 1'b0;
          end
        end
        ST_SETTLE: begin
          if (ABORT) begin
            state_q <= ST_IDLE;
            busy_q  <= 1'b0;
            pass_q  <= 1'b0;
          end else if (settle_q == '0) begin
            state_q <= ST_SAMPLE;
          end else begin
            settle_q <= settle_q - CW'(1);
          end
        end
        ST_SAMPLE: begin
          if (ABORT) begin
            state_q <= ST_IDLE;
            busy_q  <= 1'b0;
            pass_q  <= 1'b0;
          end else begin
            if (mismatch) begin
              fail_valid_q <= 1'b1;
              fail_vec_q   <= vec;
            end
            err_q <= err_d;
            // DONE/PASS are registered on entry so they are visible during FINISH.
            if (last_vec) begin
              state_q <= ST_FINISH;
              busy_q  <= 1'b0;
              done_q  <= 1'b1;
              pass_q  <= (err_d == '0);
            end else begin
              state_q  <= ST_SETTLE;
              settle_q <= SETTLE_RLD;
            end
          end
        end
        ST_FINISH: state_q <= ST_IDLE;
        default:   state_q <= ST_IDLE;
      endcase
    end
  end

  assign CUT_IN     = vec;
  assign BUSY       = busy_q;
  assign DONE       = done_q;
  assign PASS       = pass_q;
  assign FAIL_VALID = fail_valid_q;
  assign FAIL_VEC   = fail_vec_q;
  assign ERR_CNT    = err_q;

endmodule

// File: tb/tb_cell_char_seq.sv
// Scoreboard bench for cell_char_seq: default instance plus a CNT_W=2, LOOPS=2 instance.
module tb_cell_char_seq;

  typedef struct {
    bit is_done;
    int vec;
    bit pass;
    int err;
    int cyc;
  } exp_t;

  logic       ck = 1'b0;
  logic       rst;
  logic       start_a, abort_a, zn_a;
  logic [2:0] cut_in_a, fvec_a;
  logic       busy_a, done_a, pass_a, fv_a;
  logic [7:0] err_a;
  logic       start_b, abort_b, zn_b;
  logic [2:0] cut_in_b, fvec_b;
  logic       busy_b, done_b, pass_b, fv_b;
  logic [1:0] err_b;

  logic [7:0] tt = 8'h07;
  logic       flip_en;
  logic [2:0] flip_vec;

  exp_t q_a[$];
  exp_t q_b[$];
  int   n_cmp = 0;
  int   n_err = 0;
  int   cyc = 0;
  int   run0_a = 0, run0_b = 0;
  bit   busy_prev_a = 0, busy_prev_b = 0;
  int   done_cnt_a = 0;

  always #5 ck = ~ck;

  always_comb zn_a = (flip_en && (cut_in_a == flip_vec)) ? ~tt[cut_in_a] : tt[cut_in_a];
  assign zn_b = 1'b0;

  cell_char_seq u_dut_a (
    .CK(ck), .RST(rst), .START(start_a), .ABORT(abort_a), .CUT_IN(cut_in_a), .CUT_ZN(zn_a),
    .BUSY(busy_a), .DONE(done_a), .PASS(pass_a), .FAIL_VALID(fv_a), .FAIL_VEC(fvec_a),
    .ERR_CNT(err_a)
  );

  cell_char_seq #(.CNT_W(2), .LOOPS(2)) u_dut_b (
    .CK(ck), .RST(rst), .START(start_b), .ABORT(abort_b), .CUT_IN(cut_in_b), .CUT_ZN(zn_b),
    .BUSY(busy_b), .DONE(done_b), .PASS(pass_b), .FAIL_VALID(fv_b), .FAIL_VEC(fvec_b),
    .ERR_CNT(err_b)
  );

  task automatic chk(input string name, input int act, input int exp);
    n_cmp++;
    if (act != exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic unexpected(input string name, input int val);
    n_cmp++;
    n_err++;
    $display("FAIL %s: got event value %0d expected no event", name, val);
  endtask

  // Monitors: pop an expectation whenever a FAIL_VALID or DONE pulse is presented.
  always @(negedge ck) begin
    exp_t e;
    cyc++;
    if (rst) begin
      busy_prev_a = 0;
      busy_prev_b = 0;
    end else begin
      if (busy_a && !busy_prev_a) run0_a = cyc;
      busy_prev_a = busy_a;
      if (busy_b && !busy_prev_b) run0_b = cyc;
      busy_prev_b = busy_b;

      if (fv_a) begin
        if (q_a.size() == 0) unexpected("a_fail_pulse", int'(fvec_a));
        else begin
          e = q_a.pop_front();
          chk("a_evt_is_fail", 0, int'(e.is_done));
          chk("a_fail_vec", int'(fvec_a), e.vec);
          chk("a_fail_err_cnt", int'(err_a), e.err);
        end
      end
      if (done_a) begin
        done_cnt_a++;
        if (q_a.size() == 0) unexpected("a_done_pulse", int'(pass_a));
        else begin
          e = q_a.pop_front();
          chk("a_evt_is_done", 1, int'(e.is_done));
          chk("a_done_pass", int'(pass_a), int'(e.pass));
          chk("a_done_err_cnt", int'(err_a), e.err);
          chk("a_done_latency", cyc - run0_a, e.cyc);
          chk("a_done_busy_low", int'(busy_a), 0);
        end
      end

      if (fv_b) begin
        if (q_b.size() == 0) unexpected("b_fail_pulse", int'(fvec_b));
        else begin
          e = q_b.pop_front();
          chk("b_evt_is_fail", 0, int'(e.is_done));
          chk("b_fail_vec", int'(fvec_b), e.vec);
          chk("b_fail_err_cnt", int'(err_b), e.err);
        end
      end
      if (done_b) begin
        if (q_b.size() == 0) unexpected("b_done_pulse", int'(pass_b));
        else begin
          e = q_b.pop_front();
          chk("b_evt_is_done", 1, int'(e.is_done));
          chk("b_done_pass", int'(pass_b), int'(e.pass));
          chk("b_done_err_cnt", int'(err_b), e.err);
          chk("b_done_latency", cyc - run0_b, e.cyc);
        end
      end
    end
  end

  function automatic exp_t ev_fail(input int v, input int e);
    exp_t x;
    x.is_done = 0; x.vec = v; x.pass = 0; x.err = e; x.cyc = 0;
    return x;
  endfunction

  function automatic exp_t ev_done(input bit p, input int e, input int c);
    exp_t x;
    x.is_done = 1; x.vec = 0; x.pass = p; x.err = e; x.cyc = c;
    return x;
  endfunction

  task automatic pulse_start_a();
    @(negedge ck);
    start_a = 1'b1;
    @(posedge ck);
    #1 start_a = 1'b0;
  endtask

  task automatic wait_done_a(input string name, input int budget);
    bit got = 0;
    for (int i = 0; i < budget; i++) begin
      @(negedge ck);
      if (done_a) begin
        got = 1;
        break;
      end
    end
    chk(name, int'(got), 1);
  endtask

  initial begin
    bit got;
    int dc;
    rst = 1'b1;
    start_a = 0; abort_a = 0; start_b = 0; abort_b = 0;
    flip_en = 0; flip_vec = 3'd0;
    #3;
    chk("rst_cut_in", int'(cut_in_a), 0);
    chk("rst_busy", int'(busy_a), 0);
    chk("rst_done", int'(done_a), 0);
    chk("rst_pass", int'(pass_a), 0);
    chk("rst_fail_valid", int'(fv_a), 0);
    chk("rst_fail_vec", int'(fvec_a), 0);
    chk("rst_err_cnt", int'(err_a), 0);
    repeat (2) @(negedge ck);
    rst = 1'b0;

    // 1: good AOI21, CUT_IN steps 0..7 at 3 cycles each
    q_a.push_back(ev_done(1, 0, 24));
    pulse_start_a();
    chk("t1_busy_rise", int'(busy_a), 1);
    for (int k = 0; k < 24; k++) begin
      @(negedge ck);
      chk($sformatf("t1_cut_in_c%0d", k), int'(cut_in_a), k / 3);
    end
    wait_done_a("t1_done_seen", 5);
    @(negedge ck);
    chk("t1_pass_held", int'(pass_a), 1);
    chk("t1_queue_empty", q_a.size(), 0);

    // 2: ZN wrongly 1 on vector 3
    flip_en = 1; flip_vec = 3'd3;
    q_a.push_back(ev_fail(3, 1));
    q_a.push_back(ev_done(0, 1, 24));
    pulse_start_a();
    chk("t2_pass_cleared", int'(pass_a), 0);
    wait_done_a("t2_done_seen", 40);
    @(negedge ck);
    chk("t2_queue_empty", q_a.size(), 0);
    flip_en = 0;

    // 3: stuck-at-0, two loops, 2-bit counter saturates
    for (int l = 0; l < 2; l++)
      for (int v = 0; v < 3; v++)
        q_b.push_back(ev_fail(v, (l * 3 + v + 1 > 3) ? 3 : l * 3 + v + 1));
    q_b.push_back(ev_done(0, 3, 48));
    @(negedge ck);
    start_b = 1'b1;
    @(posedge ck);
    #1 start_b = 1'b0;
    got = 0;
    for (int i = 0; i < 70; i++) begin
      @(negedge ck);
      if (done_b) begin got = 1; break; end
    end
    chk("t3_done_seen", int'(got), 1);
    @(negedge ck);
    chk("t3_queue_empty", q_b.size(), 0);

    // 4: abort at vec 4 while settling, then restart from scratch
    flip_en = 1; flip_vec = 3'd3;
    q_a.push_back(ev_fail(3, 1));
    pulse_start_a();
    got = 0;
    for (int i = 0; i < 40; i++) begin
      @(negedge ck);
      if (cut_in_a == 3'd4) begin got = 1; break; end
    end
    chk("t4_reached_vec4", int'(got), 1);
    abort_a = 1'b1;
    @(posedge ck);
    #1 abort_a = 1'b0;
    chk("t4_abort_busy", int'(busy_a), 0);
    chk("t4_abort_cut_in", int'(cut_in_a), 0);
    chk("t4_abort_err_hold", int'(err_a), 1);
    chk("t4_abort_fvec_hold", int'(fvec_a), 3);
    chk("t4_abort_pass", int'(pass_a), 0);
    dc = done_cnt_a;
    repeat (30) @(negedge ck);
    chk("t4_no_done", done_cnt_a, dc);
    chk("t4_queue_empty", q_a.size(), 0);
    flip_en = 0;
    q_a.push_back(ev_done(1, 0, 24));
    pulse_start_a();
    chk("t4_restart_err", int'(err_a), 0);
    chk("t4_restart_cut_in", int'(cut_in_a), 0);
    chk("t4_restart_busy", int'(busy_a), 1);
    wait_done_a("t4_done_seen", 40);

    // 5: START+ABORT in IDLE, then a stray START mid-run
    @(negedge ck);
    start_a = 1'b1; abort_a = 1'b1;
    @(posedge ck);
    #1 begin start_a = 1'b0; abort_a = 1'b0; end
    chk("t5_abort_wins", int'(busy_a), 0);
    q_a.push_back(ev_done(1, 0, 24));
    pulse_start_a();
    repeat (10) @(negedge ck);
    start_a = 1'b1;
    @(posedge ck);
    #1 start_a = 1'b0;
    chk("t5_still_busy", int'(busy_a), 1);
    wait_done_a("t5_done_seen", 40);
    @(negedge ck);
    chk("t5_queue_empty", q_a.size(), 0);

    // 6: asynchronous reset during SAMPLE of vector 0
    flip_en = 1; flip_vec = 3'd0;
    pulse_start_a();
    @(posedge ck);
    @(posedge ck);
    #2 rst = 1'b1;
    #1;
    chk("t6_rst_busy", int'(busy_a), 0);
    chk("t6_rst_cut_in", int'(cut_in_a), 0);
    chk("t6_rst_pass", int'(pass_a), 0);
    chk("t6_rst_fail_valid", int'(fv_a), 0);
    chk("t6_rst_fail_vec", int'(fvec_a), 0);
    chk("t6_rst_err", int'(err_a), 0);
    chk("t6_rst_done", int'(done_a), 0);
    @(negedge ck);
    rst = 1'b0;
    flip_en = 0;
    repeat (5) @(negedge ck);
    chk("t6_idle_busy", int'(busy_a), 0);
    chk("t6_idle_err", int'(err_a), 0);
    chk("t6_queue_empty", q_a.size(), 0);
    q_a.push_back(ev_done(1, 0, 24));
    pulse_start_a();
    wait_done_a("t6_done_seen", 40);
    @(negedge ck);
    chk("t6_final_queue_empty", q_a.size(), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
